// File: rtl/mem_stage.sv
// Memory stage of the in-order pipeline: issues one data-memory access per load/store,
// aligns load data for writeback, and flags illegal, misaligned and timed-out accesses.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  f3,
  input  logic        d_r_en,
  input  logic        d_w_en,
  input  logic [31:0] d_add,
  input  logic [31:0] alu_out,
  input  logic [4:0]  alu_rd,
  input  logic        alu_reg_w_en,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        mis_err,
  output logic        ill_err,
  output logic        to_err
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;

  logic        w_mem;
  logic        w_ill;
  logic        w_mis;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  assign w_mem = d_r_en | d_w_en;
  assign w_mis = ((f3[1:0] == 2'b01) && d_add[0]) ||
                 ((f3[1:0] == 2'b10) && (d_add[1:0] != 2'b00));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ill = 1'b0;
    if (d_r_en && d_w_en)
      w_ill = 1'b1;
    else if (d_r_en)
      w_ill = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (d_w_en)
      w_ill = !(f3 inside {3'b000, 3'b001, 3'b010});
  end

  // Store data is replicated across lanes; the byte enables pick the lane the memory writes.
  always_comb begin
    w_wdata = '0;
    w_be    = '0;
    if (d_w_en) begin
      case (f3[1:0])
        2'b00: begin
          w_wdata = {4{alu_out[7:0]}};
          w_be    = 4'b0001 << d_add[1:0];
        end
        2'b01: begin
          w_wdata = {2{alu_out[15:0]}};
          w_be    = 4'b0011 << d_add[1:0];
        end
        default: begin
          w_wdata = alu_out;
          w_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = dm_rdata[7:0];
      2'd1:    w_byte = dm_rdata[15:8];
      2'd2:    w_byte = dm_rdata[23:16];
      default: w_byte = dm_rdata[31:24];
    endcase
    w_half = r_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r_f3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_off    <= '0;
      r_rd     <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_be    <= '0;
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      stall    <= 1'b0;
      mis_err  <= 1'b0;
      ill_err  <= 1'b0;
      to_err   <= 1'b0;
    end else begin
      // NOTE: pulses default low here and later non-blocking writes in the same cycle override them.
      wb_en   <= 1'b0;
      mis_err <= 1'b0;
      ill_err <= 1'b0;
      to_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_mem) begin
            wb_rd   <= alu_rd;
            wb_data <= alu_out;
            wb_en   <= alu_reg_w_en && (alu_rd != 5'd0);
          end else if (w_ill) begin
            ill_err <= 1'b1;
          end else if (w_mis) begin
            mis_err <= 1'b1;
          end else begin
            r_state  <= S_REQ;
            r_cnt    <= '0;
            r_f3     <= f3;
            r_off    <= d_add[1:0];
            r_rd     <= alu_rd;
            dm_req   <= 1'b1;
            stall    <= 1'b1;
            dm_we    <= d_w_en;
            dm_addr  <= {d_add[31:2], 2'b00};
            dm_wdata <= w_wdata;
            dm_be    <= w_be;
          end
        end
        S_REQ: begin
          // An ack arriving on the limit cycle completes the access instead of timing out.
          if (dm_ack) begin
            r_state <= S_IDLE;
            dm_req  <= 1'b0;
            stall   <= 1'b0;
            if (!dm_we) begin
              wb_rd   <= r_rd;
              wb_data <= w_ld_data;
              wb_en   <= (r_rd != 5'd0);
            end
          end else if (r_cnt == LP_LAST) begin
            r_state <= S_IDLE;
            dm_req  <= 1'b0;
            stall   <= 1'b0;
            to_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writeback/error events and
// memory requests; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  f3;
  logic        d_r_en, d_w_en;
  logic [31:0] d_add, alu_out;
  logic [4:0]  alu_rd;
  logic        alu_reg_w_en;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, mis_err, ill_err, to_err;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .f3(f3), .d_r_en(d_r_en), .d_w_en(d_w_en), .d_add(d_add),
    .alu_out(alu_out), .alu_rd(alu_rd), .alu_reg_w_en(alu_reg_w_en),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .mis_err(mis_err), .ill_err(ill_err), .to_err(to_err)
  );

  typedef struct packed {
    logic        wb;
    logic        mis;
    logic        ill;
    logic        to;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } rq_t;

  ev_t ev_q[$];
  rq_t rq_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  function automatic ev_t mk_ev(input logic wb, mis, ill, to, input logic [4:0] rd,
                                input logic [31:0] data);
    ev_t e;
    e.wb = wb; e.mis = mis; e.ill = ill; e.to = to; e.rd = rd; e.data = data;
    return e;
  endfunction

  function automatic rq_t mk_rq(input logic we, input logic [31:0] addr, wdata,
                                input logic [3:0] be);
    rq_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected event per pulse, one expected request per dm_req rise.
  ev_t  cur_ev;
  rq_t  cur_rq;
  logic prev_req = 1'b0;
  logic have_rq  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (wb_en === 1'b1 || mis_err === 1'b1 || ill_err === 1'b1 || to_err === 1'b1) begin
        if (ev_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_event: wb=%b mis=%b ill=%b to=%b rd=%0d data=%h",
                   wb_en, mis_err, ill_err, to_err, wb_rd, wb_data);
        end else begin
          cur_ev = ev_q.pop_front();
          check("event_flags", {wb_en, mis_err, ill_err, to_err},
                {cur_ev.wb, cur_ev.mis, cur_ev.ill, cur_ev.to});
          if (cur_ev.wb) begin
            check("wb_rd", wb_rd, cur_ev.rd);
            check("wb_data", wb_data, cur_ev.data);
          end
        end
      end
      if (dm_req === 1'b1 && prev_req !== 1'b1) begin
        if (rq_q.size() == 0) begin
          n_vec++;
          n_miss++;
          have_rq = 1'b0;
          $display("FAIL unexpected_req: addr=%h we=%b be=%b", dm_addr, dm_we, dm_be);
        end else begin
          cur_rq  = rq_q.pop_front();
          have_rq = 1'b1;
        end
      end
      if (dm_req === 1'b1 && have_rq) begin
        if (cur_rq.we)
          check("dm_store_fields", {dm_we, dm_addr, dm_wdata, dm_be}, cur_rq);
        else
          check("dm_load_fields", {dm_we, dm_addr, dm_be}, {cur_rq.we, cur_rq.addr, cur_rq.be});
      end
      prev_req = dm_req;
    end
  end

  task automatic idle_inputs();
    f3 = 3'b000; d_r_en = 1'b0; d_w_en = 1'b0; d_add = '0;
    alu_out = '0; alu_rd = '0; alu_reg_w_en = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] val, input logic [4:0] rd, input logic wen,
                        input logic exp_wb);
    if (exp_wb) ev_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 1'b0, rd, val));
    d_r_en = 1'b0; d_w_en = 1'b0; alu_out = val; alu_rd = rd; alu_reg_w_en = wen;
    @(negedge clk);
    idle_inputs();
    check("alu_no_stall", {stall, dm_req}, 2'b00);
  endtask

  task automatic err_op(input logic [2:0] f, input logic r, w, input logic [31:0] addr,
                        input logic exp_mis, exp_ill);
    ev_q.push_back(mk_ev(1'b0, exp_mis, exp_ill, 1'b0, 5'd0, 32'd0));
    f3 = f; d_r_en = r; d_w_en = w; d_add = addr; alu_out = 32'hFFFF_FFFF;
    alu_rd = 5'd1; alu_reg_w_en = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("err_no_req", {stall, dm_req}, 2'b00);
  endtask

  task automatic mem_op(input string name, input logic [2:0] f, input logic w,
                        input logic [31:0] addr, data, input logic [4:0] rd,
                        input int ack_at, input logic [31:0] rdata, input rq_t exp_rq,
                        input logic exp_wb, exp_to, input logic [31:0] exp_data,
                        input int exp_cycles);
    int n = 0;
    int n_stall = 0;
    rq_q.push_back(exp_rq);
    if (exp_wb || exp_to) ev_q.push_back(mk_ev(exp_wb, 1'b0, 1'b0, exp_to, rd, exp_data));
    f3 = f; d_r_en = !w; d_w_en = w; d_add = addr; alu_out = data;
    alu_rd = rd; alu_reg_w_en = 1'b1;
    @(negedge clk);
    idle_inputs();
    while (dm_req === 1'b1 && n < 40) begin
      n++;
      if (stall === 1'b1) n_stall++;
      if (n == ack_at) begin
        dm_ack = 1'b1;
        dm_rdata = rdata;
      end
      @(negedge clk);
      dm_ack = 1'b0;
      dm_rdata = '0;
    end
    check({name, "_req_cycles"}, n, exp_cycles);
    check({name, "_stall_cycles"}, n_stall, exp_cycles);
    check({name, "_released"}, {stall, dm_req}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    dm_ack = 1'b0;
    dm_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {dm_req, dm_we, dm_addr, dm_wdata, dm_be, wb_en, wb_rd, wb_data,
                            stall, mis_err, ill_err, to_err}, 128'd0);
    rst = 1'b0;

    alu_op(32'h1234_5678, 5'd5, 1'b1, 1'b1);
    alu_op(32'hFFFF_0000, 5'd0, 1'b1, 1'b0);
    alu_op(32'h0BAD_F00D, 5'd3, 1'b0, 1'b0);

    mem_op("lb", 3'b000, 1'b0, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_0000,
           mk_rq(1'b0, 32'h100, 32'h0, 4'b0000), 1'b1, 1'b0, 32'hFFFF_FF80, 3);
    mem_op("lbu", 3'b100, 1'b0, 32'h103, 32'h0, 5'd8, 3, 32'h80FF_0000,
           mk_rq(1'b0, 32'h100, 32'h0, 4'b0000), 1'b1, 1'b0, 32'h0000_0080, 3);
    mem_op("lb_lane1", 3'b000, 1'b0, 32'h701, 32'h0, 5'd4, 1, 32'h0000_7F00,
           mk_rq(1'b0, 32'h700, 32'h0, 4'b0000), 1'b1, 1'b0, 32'h0000_007F, 1);
    mem_op("lh", 3'b001, 1'b0, 32'h502, 32'h0, 5'd10, 2, 32'h8001_1234,
           mk_rq(1'b0, 32'h500, 32'h0, 4'b0000), 1'b1, 1'b0, 32'hFFFF_8001, 2);
    mem_op("lhu", 3'b101, 1'b0, 32'h500, 32'h0, 5'd11, 1, 32'h8001_F00D,
           mk_rq(1'b0, 32'h500, 32'h0, 4'b0000), 1'b1, 1'b0, 32'h0000_F00D, 1);
    mem_op("sh", 3'b001, 1'b1, 32'h202, 32'hAAAA_BEEF, 5'd12, 1, 32'h0,
           mk_rq(1'b1, 32'h200, 32'hBEEF_BEEF, 4'b1100), 1'b0, 1'b0, 32'h0, 1);
    mem_op("sb", 3'b000, 1'b1, 32'h301, 32'h1234_5678, 5'd13, 2, 32'h0,
           mk_rq(1'b1, 32'h300, 32'h7878_7878, 4'b0010), 1'b0, 1'b0, 32'h0, 2);
    mem_op("sw", 3'b010, 1'b1, 32'h400, 32'hDEAD_BEEF, 5'd14, 1, 32'h0,
           mk_rq(1'b1, 32'h400, 32'hDEAD_BEEF, 4'b1111), 1'b0, 1'b0, 32'h0, 1);

    err_op(3'b010, 1'b1, 1'b0, 32'h101, 1'b1, 1'b0);
    err_op(3'b001, 1'b1, 1'b0, 32'h503, 1'b1, 1'b0);
    err_op(3'b001, 1'b0, 1'b1, 32'h201, 1'b1, 1'b0);
    err_op(3'b011, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1);
    err_op(3'b010, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
    err_op(3'b100, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    err_op(3'b111, 1'b0, 1'b1, 32'h101, 1'b0, 1'b1);

    mem_op("lw_timeout", 3'b010, 1'b0, 32'h600, 32'h0, 5'd9, 0, 32'h0,
           mk_rq(1'b0, 32'h600, 32'h0, 4'b0000), 1'b0, 1'b1, 32'h0, TO);
    mem_op("lw_ack_at_limit", 3'b010, 1'b0, 32'h604, 32'h0, 5'd9, TO, 32'hCAFE_F00D,
           mk_rq(1'b0, 32'h604, 32'h0, 4'b0000), 1'b1, 1'b0, 32'hCAFE_F00D, TO);
    mem_op("lw_x0", 3'b010, 1'b0, 32'h608, 32'h0, 5'd0, 2, 32'h1111_1111,
           mk_rq(1'b0, 32'h608, 32'h0, 4'b0000), 1'b0, 1'b0, 32'h0, 2);

    // A stray ack while idle must produce nothing.
    dm_ack = 1'b1;
    dm_rdata = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    dm_ack = 1'b0;
    dm_rdata = '0;
    check("idle_ack_ignored", {stall, dm_req}, 2'b00);

    // Reset in the middle of an outstanding load.
    rq_q.push_back(mk_rq(1'b0, 32'h800, 32'h0, 4'b0000));
    f3 = 3'b010; d_r_en = 1'b1; d_add = 32'h800; alu_rd = 5'd6; alu_reg_w_en = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("pre_reset_req", {stall, dm_req}, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    dm_ack = 1'b1;
    dm_rdata = 32'h7777_7777;
    @(negedge clk);
    check("reset_mid_req", {dm_req, dm_we, dm_addr, dm_wdata, dm_be, wb_en, wb_rd, wb_data,
                            stall, mis_err, ill_err, to_err}, 128'd0);
    rst = 1'b0;
    dm_ack = 1'b0;
    dm_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    alu_op(32'h0000_00A5, 5'd31, 1'b1, 1'b1);
    @(negedge clk);

    check("event_queue_drained", ev_q.size(), 0);
    check("req_queue_drained", rq_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
